// File: rtl/serial_adder16.sv
// serial_adder16 - bit-serial two's-complement adder, LSB first.
//
// Each RUN cycle forms one full-adder bit from two half-adder stages and a
// carry flip-flop. Operands are captured on an accepted start, summed over
// WIDTH cycles, and the result is published as a registered word together
// with the final carry and a one-cycle done pulse.
//
// Optional feature: define SERIAL_ADDER_SUB_EN to add the 'sub' input.
// With sub=1 the adder computes a - b (b inverted, carry-in forced to 1);
// carry_out=1 then means no borrow. Without the macro the block is add-only.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   start      request, sampled only in IDLE
//   a, b       operands, sampled on the accepted start edge
//   sub        (SERIAL_ADDER_SUB_EN only) subtract request, sampled with a/b
//   busy       high while in RUN
//   done       one-cycle pulse when out/carry_out have just been updated
//   out        registered sum, holds until the next completion
//   carry_out  final carry of the MSB, holds with out
//
// state  | meaning
// IDLE   | waiting for start; out/carry_out hold last result
// RUN    | one sum bit per cycle, WIDTH cycles
// DONE   | result published, done asserted for this single cycle

module serial_adder16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carry_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_ff_q, carry_ff_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_out_q, carry_out_d;

    logic [WIDTH-1:0] b_in;
    logic             carry_in;
    logic             s0, c0, sum_bit, c1;

    // Operand B conditioning: subtraction is a + ~b + 1.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_in     = sub ? ~b : b;
    assign carry_in = sub;
`else
    assign b_in     = b;
    assign carry_in = 1'b0;
`endif

    // Two half-adder stages make up the full adder for the current bit.
    assign s0      = sa_q[0] ^ sb_q[0];
    assign c0      = sa_q[0] & sb_q[0];
    assign sum_bit = s0 ^ carry_ff_q;
    assign c1      = s0 & carry_ff_q;

    always_comb begin
        state_d     = state_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        carry_ff_d  = carry_ff_q;
        out_d       = out_q;
        carry_out_d = carry_out_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d       = a;
                    sb_d       = b_in;
                    carry_ff_d = carry_in;
                    cnt_d      = '0;
                    acc_d      = '0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                carry_ff_d = c0 | c1;
                acc_d      = {sum_bit, acc_q[WIDTH-1:1]};
                sa_d       = sa_q >> 1;
                sb_d       = sb_q >> 1;
                cnt_d      = cnt_q + CNT_W'(1);
                // The last bit lands in acc_d this cycle, so publish acc_d
                // rather than acc_q.
                if (cnt_q == CNT_LAST) begin
                    out_d       = acc_d;
                    carry_out_d = c0 | c1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sa_q        <= '0;
            sb_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            carry_ff_q  <= 1'b0;
            out_q       <= '0;
            carry_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            carry_ff_q  <= carry_ff_d;
            out_q       <= out_d;
            carry_out_q <= carry_out_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign out       = out_q;
    assign carry_out = carry_out_q;

endmodule
